// File: rtl/decoder_onehot_seq_if.sv
// ============================================================================
// Module      : decoder_onehot_seq_if
// Description : Handshake and output bundle for decoder_onehot_seq.
//               master modport: code producer (drives valid/sel/mode/clr).
//               slave modport : the decoder (drives ready and decoded outputs).
// Ports       : in_valid, in_ready, in_sel[SEL_W], pulse_mode, clr,
//               decoded[OUT_W], active, done, err
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface decoder_onehot_seq_if #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             pulse_mode;
  logic             clr;
  logic [OUT_W-1:0] decoded;
  logic             active;
  logic             done;
  logic             err;

  modport master (
    output in_valid, in_sel, pulse_mode, clr,
    input  in_ready, decoded, active, done, err
  );

  modport slave (
    input  in_valid, in_sel, pulse_mode, clr,
    output in_ready, decoded, active, done, err
  );
endinterface

`default_nettype wire

// File: rtl/decoder_onehot_seq.sv
// ============================================================================
// Module      : decoder_onehot_seq
// Description : Registered binary-to-one-hot decoder with valid/ready input.
//               Accepted codes drive one output line either held (level mode,
//               dropped by clr) or strobed for PULSE_CYC cycles (pulse mode,
//               followed by a one-cycle done). Codes >= OUT_W give a one-cycle
//               err and no output line.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - decoder_onehot_seq_if.slave (handshake + outputs)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module decoder_onehot_seq #(
  parameter int SEL_W     = 3,
  parameter int OUT_W     = 8,
  parameter int PULSE_CYC = 1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  decoder_onehot_seq_if.slave     bus
);

  localparam int               c_CNT_W    = $clog2(PULSE_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(PULSE_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [OUT_W-1:0] c_ONE      = {{(OUT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    PULSE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [OUT_W-1:0]   r_decoded, w_decoded_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_active;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;

  logic               w_ready;
  logic               w_accept;
  logic               w_out_of_range;
  logic [OUT_W-1:0]   w_onehot;

  // clr blocks acceptance so a simultaneous clear and new code resolve to clear.
  assign w_ready        = (r_state != PULSE) & ~bus.clr;
  assign w_accept       = bus.in_valid & w_ready;
  // Widen before comparing so OUT_W == 2**SEL_W compares correctly.
  assign w_out_of_range = 32'(bus.in_sel) >= 32'(OUT_W);
  // Shift is truncated to OUT_W; out-of-range codes are masked separately.
  assign w_onehot       = c_ONE << bus.in_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_decoded <= '0;
      r_cnt     <= '0;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_decoded <= w_decoded_nxt;
      r_cnt     <= w_cnt_nxt;
      r_active  <= |w_decoded_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_decoded_nxt = r_decoded;
    w_cnt_nxt     = r_cnt;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      IDLE, HOLD: begin
        if (w_accept) begin
          if (w_out_of_range) begin
            w_decoded_nxt = '0;
            w_err_nxt     = 1'b1;
            w_state_nxt   = IDLE;
          end else begin
            w_decoded_nxt = w_onehot;
            if (bus.pulse_mode) begin
              w_state_nxt = PULSE;
              w_cnt_nxt   = c_CNT_LOAD;
            end else begin
              w_state_nxt = HOLD;
            end
          end
        end else if ((r_state == HOLD) && bus.clr) begin
          w_decoded_nxt = '0;
          w_state_nxt   = IDLE;
        end
      end

      PULSE: begin
        // Counter was loaded with PULSE_CYC-1, so the line stays up PULSE_CYC cycles.
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end else begin
          w_decoded_nxt = '0;
          w_done_nxt    = 1'b1;
          w_state_nxt   = IDLE;
        end
      end

      default: begin
        w_state_nxt   = IDLE;
        w_decoded_nxt = '0;
        w_cnt_nxt     = '0;
      end
    endcase
  end

  assign bus.in_ready = w_ready;
  assign bus.decoded  = r_decoded;
  assign bus.active   = r_active;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule

`default_nettype wire
